// File: rtl/fpaddsub_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fpaddsub_arbiter
// Description : Round-robin, credit-based sharing of one pipelined FP
//               add/sub unit between two requesters, with per-requester
//               in-order response FIFOs.
// Revision    : 1.0  initial release
// ============================================================================
module fpaddsub_arbiter #(
   parameter int LATENCY = 11,
   parameter int DEPTH   = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic        req0_ctrl,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   input  logic        req1_ctrl,
   output logic        rsp0_valid,
   input  logic        rsp0_ready,
   output logic [31:0] rsp0_z,
   output logic [4:0]  rsp0_flags,
   output logic        rsp1_valid,
   input  logic        rsp1_ready,
   output logic [31:0] rsp1_z,
   output logic [4:0]  rsp1_flags,
   output logic [31:0] fpu_a,
   output logic [31:0] fpu_b,
   output logic        fpu_ctrl,
   input  logic [31:0] fpu_z,
   input  logic [4:0]  fpu_flags,
   output logic        busy
);

   localparam int PW = $clog2(DEPTH);
   localparam int OW = $clog2(DEPTH + 1);
   localparam logic [OW-1:0] c_occ_full = OW'(DEPTH);
   localparam logic [OW-1:0] c_occ_one  = OW'(1);
   localparam logic [PW:0]   c_ptr_one  = (PW + 1)'(1);

   logic [1:0]       w_req_valid;
   logic [1:0]       w_rsp_ready;
   logic [1:0]       w_elig;
   logic [1:0]       w_grant;
   logic [1:0]       w_push;
   logic [1:0]       w_pop;
   logic [1:0]       w_rsp_valid;
   logic [1:0]       w_occ_nz;
   logic [1:0][31:0] w_rsp_z;
   logic [1:0][4:0]  w_rsp_flags;

   logic               r_prio;
   logic               r_iss_v;
   logic               r_iss_tag;
   logic [31:0]        r_fpu_a;
   logic [31:0]        r_fpu_b;
   logic               r_fpu_ctrl;
   logic [LATENCY-1:0] r_trk_v;
   logic [LATENCY-1:0] r_trk_t;

   assign w_req_valid = {req1_valid, req0_valid};
   assign w_rsp_ready = {rsp1_ready, rsp0_ready};

   // r_prio names the requester that wins when both are eligible
   always_comb begin
      w_grant = 2'b00;
      if (w_elig[0] && (!w_elig[1] || !r_prio))
         w_grant[0] = 1'b1;
      else if (w_elig[1])
         w_grant[1] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_prio     <= 1'b0;
         r_iss_v    <= 1'b0;
         r_iss_tag  <= 1'b0;
         r_fpu_a    <= 32'd0;
         r_fpu_b    <= 32'd0;
         r_fpu_ctrl <= 1'b0;
         r_trk_v    <= '0;
         r_trk_t    <= '0;
      end else begin
         r_iss_v    <= |w_grant;
         r_iss_tag  <= w_grant[1];
         r_fpu_a    <= w_grant[1] ? req1_a    : (w_grant[0] ? req0_a    : 32'd0);
         r_fpu_b    <= w_grant[1] ? req1_b    : (w_grant[0] ? req0_b    : 32'd0);
         r_fpu_ctrl <= w_grant[1] ? req1_ctrl : (w_grant[0] ? req0_ctrl : 1'b0);
         if (|w_grant)
            r_prio <= w_grant[0];
         r_trk_v <= {r_trk_v[LATENCY-2:0], r_iss_v};
         r_trk_t <= {r_trk_t[LATENCY-2:0], r_iss_tag};
      end
   end

   genvar n;
   generate
      for (n = 0; n < 2; n++) begin : g_req
         logic [31:0]   r_mem_z [DEPTH];
         logic [4:0]    r_mem_f [DEPTH];
         logic [PW:0]   r_wp;
         logic [PW:0]   r_rp;
         logic [OW-1:0] r_occ;

         // occupancy covers in-flight plus queued, so a push never overflows
         assign w_elig[n]      = w_req_valid[n] && (r_occ != c_occ_full);
         assign w_push[n]      = r_trk_v[LATENCY-1] && (r_trk_t[LATENCY-1] == (n != 0));
         assign w_rsp_valid[n] = (r_wp != r_rp) && !rst;
         assign w_pop[n]       = w_rsp_valid[n] && w_rsp_ready[n];
         assign w_rsp_z[n]     = r_mem_z[r_rp[PW-1:0]];
         assign w_rsp_flags[n] = r_mem_f[r_rp[PW-1:0]];
         assign w_occ_nz[n]    = (r_occ != '0);

         always_ff @(posedge clk) begin
            if (w_push[n]) begin
               r_mem_z[r_wp[PW-1:0]] <= fpu_z;
               r_mem_f[r_wp[PW-1:0]] <= fpu_flags;
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               r_wp  <= '0;
               r_rp  <= '0;
               r_occ <= '0;
            end else begin
               if (w_push[n])
                  r_wp <= r_wp + c_ptr_one;
               if (w_pop[n])
                  r_rp <= r_rp + c_ptr_one;
               if (w_grant[n] && !w_pop[n])
                  r_occ <= r_occ + c_occ_one;
               else if (!w_grant[n] && w_pop[n])
                  r_occ <= r_occ - c_occ_one;
            end
         end
      end
   endgenerate

   assign req0_ready = w_grant[0] && !rst;
   assign req1_ready = w_grant[1] && !rst;
   assign rsp0_valid = w_rsp_valid[0];
   assign rsp1_valid = w_rsp_valid[1];
   assign rsp0_z     = w_rsp_z[0];
   assign rsp1_z     = w_rsp_z[1];
   assign rsp0_flags = w_rsp_flags[0];
   assign rsp1_flags = w_rsp_flags[1];
   assign fpu_a      = rst ? 32'd0 : r_fpu_a;
   assign fpu_b      = rst ? 32'd0 : r_fpu_b;
   assign fpu_ctrl   = rst ? 1'b0  : r_fpu_ctrl;
   assign busy       = (|w_occ_nz) && !rst;

endmodule
`default_nettype wire
